// File: rtl/key_output_fifo.sv
// Keypoint output FIFO.
// Captures scored keypoints from the keypoint buffer during a frame, holds
// them in a show-ahead FIFO and hands them downstream on a valid/ready port.
// A small IDLE/RUN/FLUSH controller tracks the frame and pulses
// o_frame_done once the FIFO has drained after the last pixel.
//
// Handshake: a keypoint leaves the FIFO on every rising edge where
// o_valid=1 and i_ready=1; o_valid depends only on registered state and
// never on i_ready or i_hit, and the data outputs stay stable while
// o_valid=1 and no pop occurs.
//
// DEPTH must be a power of two and at least 4. The pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
// o_state_dbg exposes the controller state: 0=IDLE, 1=RUN, 2=FLUSH.
module key_output_fifo #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [7:0]  SCORE_MIN = 8'd0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_frame_start,
    input  logic        i_frame_end,
    input  logic        i_hit,
    input  logic [9:0]  i_coor_x,
    input  logic [9:0]  i_coor_y,
    input  logic [9:0]  i_depth,
    input  logic [7:0]  i_score,
    input  logic [11:0] i_sin,
    input  logic [11:0] i_cos,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [9:0]  o_coor_x,
    output logic [9:0]  o_coor_y,
    output logic [9:0]  o_depth,
    output logic [7:0]  o_score,
    output logic [11:0] o_sin,
    output logic [11:0] o_cos,
    output logic [9:0]  o_kp_count,
    output logic        o_overflow,
    output logic        o_frame_done,
    output logic        o_full,
    output logic        o_empty,
    output logic [1:0]  o_state_dbg
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = 62;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW:0]     wptr_q, wptr_d;
    logic [AW:0]     rptr_q, rptr_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [9:0]      kp_count_q, kp_count_d;
    logic            overflow_q, overflow_d;

    logic            full;
    logic            empty;
    logic            push_req;
    logic            restart;
    logic            do_pop;
    logic            accept;
    logic            drop;
    logic            frame_done;
    logic [AW-1:0]   waddr;
    logic [EW-1:0]   wdata;
    logic [EW-1:0]   head;

    // Occupancy: equal pointers mean empty, differing only in the wrap bit means full.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // Vacant buffer slots carry score 0 and never exceed SCORE_MIN, so they are skipped.
    assign push_req = (state_q != ST_IDLE) && i_hit && (i_score > SCORE_MIN);

    // A new frame starting mid-frame discards whatever is still queued.
    assign restart = i_frame_start && (state_q != ST_IDLE);

    // A pop on the discarding cycle is meaningless since the contents are dropped anyway.
    assign do_pop = !empty && i_ready && !restart;

    // Full with a simultaneous pop frees the head slot, so the push still fits.
    assign accept = push_req && (restart || !full || do_pop);
    assign drop   = push_req && !accept;

    assign waddr = restart ? '0 : wptr_q[AW-1:0];
    assign wdata = {i_coor_x, i_coor_y, i_depth, i_score, i_sin, i_cos};

    // Controller next state and the frame-done pulse; i_frame_start wins over i_frame_end.
    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_frame_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_frame_start) begin
                    state_d = ST_RUN;
                end else if (i_frame_end) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (i_frame_start) begin
                    state_d = ST_RUN;
                end else if (empty) begin
                    state_d    = ST_IDLE;
                    frame_done = !i_rst;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pointer, keypoint counter and overflow flag next-state logic.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        kp_count_d = kp_count_q;
        overflow_d = overflow_q;

        if (restart) begin
            wptr_d = accept ? (AW+1)'(1) : '0;
            rptr_d = '0;
        end else begin
            if (accept) begin
                wptr_d = wptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + (AW+1)'(1);
            end
        end

        if (i_frame_start) begin
            kp_count_d = accept ? 10'd1 : 10'd0;
            overflow_d = 1'b0;
        end else begin
            if (accept && (kp_count_q != 10'd1023)) begin
                kp_count_d = kp_count_q + 10'd1;
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Control registers with synchronous reset overriding every other input.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            kp_count_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            kp_count_q <= kp_count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage; contents are only visible through the head mux, so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (!i_rst && accept) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Show-ahead head; an empty FIFO presents zeros rather than stale storage.
    assign head = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    assign o_coor_x     = head[61:52];
    assign o_coor_y     = head[51:42];
    assign o_depth      = head[41:32];
    assign o_score      = head[31:24];
    assign o_sin        = head[23:12];
    assign o_cos        = head[11:0];

    assign o_valid      = !empty;
    assign o_empty      = empty;
    assign o_full       = full;
    assign o_kp_count   = kp_count_q;
    assign o_overflow   = overflow_q;
    assign o_frame_done = frame_done;
    assign o_state_dbg  = state_q;

endmodule

// File: doc/key_output_fifo.md
KEY_OUTPUT_FIFO -- requirements
Module: key_output_fifo

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Parameter DEPTH SHALL default to 16 and set the number of FIFO entries; it SHALL be a power of 2 and at least 4.
REQ-003 Parameter SCORE_MIN SHALL default to 8'd0 and set the score a keypoint must exceed to be captured.
REQ-004 i_clk  input  1  SHALL be the clock; every register updates on its rising edge.
REQ-005 i_rst  input  1  SHALL be the synchronous active-high reset.
REQ-006 i_frame_start  input  1  SHALL be a one-cycle pulse marking the start of a frame.
REQ-007 i_frame_end  input  1  SHALL be a one-cycle pulse marking that the last pixel of the frame has been issued.
REQ-008 i_hit  input  1  SHALL indicate that the keypoint buffer is emitting its head entry this cycle.
REQ-009 i_coor_x, i_coor_y, i_depth  input  10 each  SHALL carry the head keypoint's coordinates and depth.
REQ-010 i_score  input  8  SHALL carry the head keypoint's score.
REQ-011 i_sin, i_cos  input  12 each  SHALL carry the head keypoint's orientation.
REQ-012 i_ready  input  1  SHALL be the downstream consumer ready signal.
REQ-013 o_valid  output  1  SHALL indicate that the FIFO head is presented on the data outputs.
REQ-014 o_coor_x, o_coor_y, o_depth (10 bits each), o_score (8 bits), o_sin and o_cos (12 bits each) SHALL be outputs carrying the FIFO head entry.
REQ-015 o_kp_count  output  10  SHALL report the number of keypoints accepted this frame.
REQ-016 o_overflow  output  1  SHALL be a sticky flag that is set when a keypoint has been dropped this frame.
REQ-017 o_frame_done  output  1  SHALL be a one-cycle pulse marking that the frame has fully drained.
REQ-018 o_full and o_empty  output  1 each  SHALL report the FIFO occupancy status.

Function
REQ-019 The state machine SHALL have three states: IDLE, RUN and FLUSH.
REQ-020 IDLE SHALL go to RUN on i_frame_start.
REQ-021 RUN SHALL go to FLUSH on i_frame_end.
REQ-022 FLUSH SHALL go to IDLE in the cycle the FIFO becomes empty, with o_frame_done=1 for exactly that one cycle.
REQ-023 FLUSH with an already empty FIFO SHALL pulse o_frame_done on the next cycle.
REQ-024 A push SHALL be requested when state is RUN or FLUSH, i_hit=1 and i_score>SCORE_MIN; zero-score (vacant) buffer slots SHALL therefore never be captured.
REQ-025 i_hit in IDLE SHALL be ignored.
REQ-026 A pop SHALL occur when o_valid=1 and i_ready=1.
REQ-027 The FIFO SHALL be show-ahead: the data outputs always equal the head entry, and a pushed entry SHALL appear on the outputs the cycle after the push when the FIFO was empty.
REQ-028 o_valid SHALL equal !o_empty.
REQ-029 When the FIFO is not full, a push SHALL always be accepted.
REQ-030 When the FIFO is full and a pop occurs in the same cycle, the push SHALL be accepted and occupancy SHALL stay at DEPTH.
REQ-031 When the FIFO is full and no pop occurs, the push SHALL be dropped, FIFO contents SHALL be unchanged, and o_overflow SHALL set.
REQ-032 A simultaneous push and pop on an empty FIFO SHALL NOT occur, because o_valid=0 blocks the pop; the push SHALL be accepted.
REQ-033 The read and write pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH.
REQ-034 The FIFO SHALL be full when the pointers differ only in the MSB, and empty when the pointers are equal.
REQ-035 o_kp_count SHALL increment on each accepted push and saturate at 1023.
REQ-036 i_frame_start in RUN or FLUSH SHALL empty the FIFO, clear o_kp_count and o_overflow, and enter RUN.
REQ-037 A hit in the same cycle as such an i_frame_start SHALL be accepted into the new frame, giving o_kp_count=1 on the next cycle.
REQ-038 i_frame_start in IDLE SHALL also clear o_kp_count and o_overflow.
REQ-039 i_frame_end outside RUN SHALL be ignored.
REQ-040 When i_frame_start and i_frame_end are asserted together, i_frame_start SHALL take priority.
REQ-041 Data outputs SHALL be driven from registers or storage, with no combinational path from i_hit to o_valid.

Reset
REQ-042 On i_rst=1 the state SHALL become IDLE and both pointers SHALL become 0.
REQ-043 On reset, o_valid=0, o_empty=1, o_full=0, o_kp_count=0, o_overflow=0 and o_frame_done=0.
REQ-044 All data outputs SHALL read 0 after reset.
REQ-045 Reset asserted mid-frame SHALL discard all FIFO contents, and no o_frame_done SHALL be produced.
REQ-046 Reset SHALL override every other input in the same cycle.

Verification
REQ-047 Basic capture: reset; frame_start; one hit with x=100, y=50, score=20, i_ready=1 -> o_valid=1 the next cycle showing x=100, y=50; o_kp_count=1.
REQ-048 Vacant slot: hit with score=0 -> no push, o_empty stays 1, o_kp_count stays 0.
REQ-049 Overflow: i_ready=0; 17 hits with scores 1..17 -> o_full=1 after the 16th, o_overflow=1 after the 17th, o_kp_count=16; draining yields scores 1..16 in order.
REQ-050 Full with pop: FIFO full; hit and pop in the same cycle -> occupancy stays 16, o_overflow stays 0, and the new entry lands last.
REQ-051 Flush: 3 entries queued; frame_end; i_ready=1 -> 3 pops, then o_frame_done pulses once and state returns to IDLE.
REQ-052 Mid-frame events: frame_start with 5 entries queued -> o_empty=1, o_kp_count=0; i_rst asserted with entries queued -> all reset values, and no o_frame_done is produced.
